memory_unloader: RTL and testbench

Streams stored words out of a TPU MAC memory onto an 8-bit output port. It is the read-side counterpart of the memory loader. On a start command it reads a contiguous, wrapping address range through a synchronous read port with one-cycle latency. It narrows each word to 8 bits and presents the words in order on a valid/ready port, typically to unload the 16 matrix-multiply results held in the upper half of weight memory.

---
 rtl/tpu_mac_pkg.sv | 22 ++
 rtl/memory_unloader_if.sv | 35 +++
 rtl/unload_skid_fifo.sv | 71 +++++++
 rtl/memory_unloader.sv | 129 ++++++++++++
 tb/tb_memory_unloader.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_mac_pkg.sv
// Shared constants and types for the TPU MAC memory unloader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default widths, unloader FSM state enum, saturation bounds for the default output width.
package tpu_mac_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 16;
    localparam int OUT_W_DEF  = 8;

    // Clamp range of a signed OUT_W_DEF-bit output word
    localparam int SAT_MAX_DEF = (1 << (OUT_W_DEF - 1)) - 1;
    localparam int SAT_MIN_DEF = -(1 << (OUT_W_DEF - 1));

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/memory_unloader_if.sv
// Bundle of command, memory read port and output stream signals of the unloader.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready on the stream side; the memory port has no backpressure.
// Modports: master = the unloader, slave = the surrounding environment (command source, memory, sink).
interface memory_unloader_if import tpu_mac_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
);
    // command / status
    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic [ADDR_W:0]          count;
    logic                     busy;
    logic                     done;
    // synchronous memory read port (1-cycle latency)
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    // output stream
    logic signed [OUT_W-1:0]  port_out;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        input  start, base_addr, count, rd_data, out_ready,
        output busy, done, rd_en, rd_addr, port_out, out_valid
    );

    modport slave (
        output start, base_addr, count, rd_data, out_ready,
        input  busy, done, rd_en, rd_addr, port_out, out_valid
    );

endinterface

// File: rtl/unload_skid_fifo.sv
// 2-entry registered FIFO that narrows DATA_W words to OUT_W on write.
// Latency: a pushed word is visible on dat_o/vld_o the cycle after the push.
// Backpressure: none internally; the caller must never push into a full FIFO without popping.
// Ports: clk, rst (sync, active-high), push_i/push_dat_i write side, pop_i read side,
//        vld_o/dat_o head of queue, occ_o occupancy (0..2).
// Config: MEM_UNLOADER_SAT_EN selects clamping instead of two's-complement truncation.
module unload_skid_fifo import tpu_mac_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic signed [DATA_W-1:0] push_dat_i,
    input  logic                     pop_i,
    output logic                     vld_o,
    output logic signed [OUT_W-1:0]  dat_o,
    output logic [1:0]               occ_o
);

    logic signed [OUT_W-1:0] entry_q [2];
    logic                    wr_ptr_q;
    logic                    rd_ptr_q;
    logic [1:0]              occ_q;
    logic signed [OUT_W-1:0] narrow;

`ifdef MEM_UNLOADER_SAT_EN
    localparam int SAT_HI = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_LO = -(1 << (OUT_W - 1));

    // Clamp on the write side so the head register already holds the final value
    always_comb begin
        narrow = push_dat_i[OUT_W-1:0];
        if (int'(push_dat_i) > SAT_HI) begin
            narrow = OUT_W'(SAT_HI);
        end else if (int'(push_dat_i) < SAT_LO) begin
            narrow = OUT_W'(SAT_LO);
        end
    end
`else
    logic unused_hi;

    assign narrow    = push_dat_i[OUT_W-1:0];
    assign unused_hi = ^push_dat_i[DATA_W-1:OUT_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            if (push_i) begin
                entry_q[wr_ptr_q] <= narrow;
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Head entry only moves on a pop, so the output is stable while stalled
    assign vld_o = (occ_q != 2'd0);
    assign dat_o = entry_q[rd_ptr_q];
    assign occ_o = occ_q;

endmodule

// File: rtl/memory_unloader.sv
// Streams a wrapping address range out of a synchronous-read memory onto a narrow valid/ready port.
// Latency: first out_valid 3 edges after the start edge, then 1 word/cycle while out_ready=1.
// Backpressure: reads are throttled so FIFO occupancy plus reads in flight never exceeds 2.
// Ports: clk, rst (sync, active-high), bus (memory_unloader_if.master: command/status,
//        memory read port, output stream).
// Config: MEM_UNLOADER_SAT_EN (clamp instead of truncate) is handled inside unload_skid_fifo.
module memory_unloader import tpu_mac_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    memory_unloader_if.master  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_e                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         remaining_q, remaining_d;
    logic                    inflight_q;

    logic                    hs;
    logic                    rd_go;
    logic [1:0]              occ;
    logic [2:0]              pending;
    logic                    fifo_vld;
    logic signed [OUT_W-1:0] fifo_dat;

    assign hs = fifo_vld && bus.out_ready;

    // Words already owed to the sink after this cycle's handshake; hs implies occ>=1, so no underflow
    assign pending = 3'(occ) + 3'(inflight_q) - 3'(hs);

    // Issue only while a slot is guaranteed when the data lands next cycle
    assign rd_go = (state_q == ST_RUN) && (pending < 3'd2);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_go && (remaining_q == CNT_ONE)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish on the edge of the last handshake so done follows it directly
                if (pending == 3'd0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        bus.busy    = (state_q != ST_IDLE);
        bus.done    = (state_q == ST_DONE);
        bus.rd_en   = rd_go;
        bus.rd_addr = addr_q;
    end

    // ---------------- read address / count datapath ----------------
    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        if ((state_q == ST_IDLE) && bus.start) begin
            addr_d      = bus.base_addr;
            remaining_d = bus.count;
        end else if (rd_go) begin
            // Natural ADDR_W overflow gives the modulo-depth wrap
            addr_d      = addr_q + ADDR_ONE;
            remaining_d = remaining_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= rd_go;
        end
    end

    unload_skid_fifo #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inflight_q),
        .push_dat_i (bus.rd_data),
        .pop_i      (hs),
        .vld_o      (fifo_vld),
        .dat_o      (fifo_dat),
        .occ_o      (occ)
    );

    assign bus.out_valid = fifo_vld;
    assign bus.port_out  = fifo_dat;

endmodule

// File: tb/tb_memory_unloader.sv
// Self-checking bench for memory_unloader: memory model, random sink, event monitor, scenario tasks.
// Latency: n/a.
// Backpressure: out_ready driven high, low-random, per scenario.
module tb_memory_unloader;
    import tpu_mac_pkg::*;

    localparam int AW    = ADDR_W_DEF;
    localparam int DW    = DATA_W_DEF;
    localparam int OW    = OUT_W_DEF;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    memory_unloader_if #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) bus ();

    memory_unloader #(.ADDR_W(AW), .DATA_W(DW), .OUT_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- memory model: synchronous read, 1-cycle latency ----------------
    logic signed [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // ---------------- sink: 0 = always ready, 1 = random ----------------
    int rdy_mode = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) bus.out_ready = 1'($urandom_range(0, 1));
            else               bus.out_ready = 1'b1;
        end
    end

    // ---------------- monitor (sole writer of the logs) ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int hs_val[$];
    int hs_cyc[$];
    int rd_log[$];
    int done_log[$];
    int vld_rise[$];
    int stall_viol  = 0;
    int over2       = 0;
    int outstanding = 0;
    logic prev_stall = 1'b0;
    logic prev_vld   = 1'b0;
    logic signed [OW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        if (rst) begin
            outstanding <= 0;
            prev_stall  <= 1'b0;
            prev_vld    <= 1'b0;
        end else begin
            if (prev_stall && (!bus.out_valid || bus.port_out !== prev_dat)) stall_viol <= stall_viol + 1;
            if (bus.out_valid && !prev_vld) vld_rise.push_back(cyc);
            if (bus.rd_en) rd_log.push_back(int'(bus.rd_addr));
            if (bus.out_valid && bus.out_ready) begin
                hs_val.push_back(int'(bus.port_out));
                hs_cyc.push_back(cyc);
            end
            if (bus.done) done_log.push_back(cyc);
            if (outstanding + int'(bus.rd_en) - int'(bus.out_valid && bus.out_ready) > 2) over2 <= over2 + 1;
            outstanding <= outstanding + int'(bus.rd_en) - int'(bus.out_valid && bus.out_ready);
            prev_stall  <= bus.out_valid && !bus.out_ready;
            prev_dat    <= bus.port_out;
            prev_vld    <= bus.out_valid;
        end
    end

    // ---------------- reference: what the sink should see for a stored word ----------------
    function automatic int ref_word(input int w);
`ifdef MEM_UNLOADER_SAT_EN
        if (w > SAT_MAX_DEF) return SAT_MAX_DEF;
        if (w < SAT_MIN_DEF) return SAT_MIN_DEF;
        return w;
`else
        int span = 1 << OW;
        int m    = ((w % span) + span) % span;
        return (m >= span / 2) ? m - span : m;
`endif
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic pulse_start(input int b, input int c, output int s);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.base_addr = AW'(b);
        bus.count     = (AW + 1)'(c);
        s             = cyc;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.done !== 1'b0)      begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
        total++; if (bus.rd_en !== 1'b0)     begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
        total++; if (bus.rd_addr !== '0)     begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.port_out !== '0)    begin bad++; $display("FAIL reset_port_out: got %0d want 0", bus.port_out); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_full_rate();
        int s, h0, r0, d0, v0, n;
        bit ok;
        fill_random();
        for (int i = 0; i < 16; i++) mem[16 + i] = DW'(i);
        rdy_mode = 0;
        idle_cycles(2);
        h0 = hs_val.size(); r0 = rd_log.size(); d0 = done_log.size(); v0 = vld_rise.size();
        pulse_start(16, 16, s);
        wait_done(200, ok);
        idle_cycles(1);
        total++; if (!ok) begin bad++; $display("FAIL full_done_timeout: got no done want done"); end
        n = hs_val.size() - h0;
        total++; if (n !== 16) begin bad++; $display("FAIL full_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            total++; if (hs_val[h0 + i] !== i) begin bad++; $display("FAIL full_data[%0d]: got %0d want %0d", i, hs_val[h0 + i], i); end
        end
        if (n >= 16) begin
            total++; if (hs_cyc[h0 + 15] - hs_cyc[h0] !== 15) begin bad++; $display("FAIL full_consecutive: got span %0d want 15", hs_cyc[h0 + 15] - hs_cyc[h0]); end
            if (done_log.size() > d0) begin
                total++; if (done_log[d0] !== hs_cyc[h0 + 15] + 1) begin bad++; $display("FAIL full_done_cycle: got %0d want %0d", done_log[d0], hs_cyc[h0 + 15] + 1); end
            end
        end
        total++; if (vld_rise.size() <= v0 || vld_rise[v0] - s !== 3) begin bad++; $display("FAIL full_first_valid_latency: got %0d want 3", (vld_rise.size() > v0) ? vld_rise[v0] - s : -1); end
        total++; if (rd_log.size() - r0 !== 16) begin bad++; $display("FAIL full_rd_en_pulses: got %0d want 16", rd_log.size() - r0); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL full_after_done: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_backpressure();
        int s, h0, r0, sv0, o0, n;
        bit ok;
        for (int i = 0; i < 16; i++) mem[16 + i] = DW'(i);
        rdy_mode = 1;
        idle_cycles(2);
        h0 = hs_val.size(); r0 = rd_log.size(); sv0 = stall_viol; o0 = over2;
        pulse_start(16, 16, s);
        wait_done(400, ok);
        rdy_mode = 0;
        idle_cycles(2);
        total++; if (!ok) begin bad++; $display("FAIL bp_done_timeout: got no done want done"); end
        n = hs_val.size() - h0;
        total++; if (n !== 16) begin bad++; $display("FAIL bp_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            total++; if (hs_val[h0 + i] !== i) begin bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, hs_val[h0 + i], i); end
        end
        total++; if (stall_viol - sv0 !== 0) begin bad++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_viol - sv0); end
        total++; if (over2 - o0 !== 0) begin bad++; $display("FAIL bp_outstanding: got %0d cycles over 2 want 0", over2 - o0); end
        total++; if (rd_log.size() - r0 !== 16) begin bad++; $display("FAIL bp_rd_en_pulses: got %0d want 16", rd_log.size() - r0); end
    endtask

    task automatic test_saturation();
        int s, h0, n;
        int exp_v[4];
        bit ok;
`ifdef MEM_UNLOADER_SAT_EN
        exp_v = '{SAT_MAX_DEF, SAT_MIN_DEF, 127, -128};
`else
        exp_v = '{44, -44, 127, -128};
`endif
        mem[8] = DW'(300); mem[9] = DW'(-300); mem[10] = DW'(127); mem[11] = DW'(-128);
        rdy_mode = 0;
        h0 = hs_val.size();
        pulse_start(8, 4, s);
        wait_done(100, ok);
        idle_cycles(2);
        total++; if (!ok) begin bad++; $display("FAIL sat_done_timeout: got no done want done"); end
        n = hs_val.size() - h0;
        total++; if (n !== 4) begin bad++; $display("FAIL sat_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            total++; if (hs_val[h0 + i] !== exp_v[i]) begin bad++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, hs_val[h0 + i], exp_v[i]); end
        end
    endtask

    task automatic test_wrap();
        int s, h0, r0, n;
        int exp_a[4];
        bit ok;
        exp_a = '{30, 31, 0, 1};
        fill_random();
        rdy_mode = 1;
        h0 = hs_val.size(); r0 = rd_log.size();
        pulse_start(30, 4, s);
        wait_done(200, ok);
        rdy_mode = 0;
        idle_cycles(2);
        total++; if (!ok) begin bad++; $display("FAIL wrap_done_timeout: got no done want done"); end
        total++; if (rd_log.size() - r0 !== 4) begin bad++; $display("FAIL wrap_rd_count: got %0d want 4", rd_log.size() - r0); end
        for (int i = 0; i < rd_log.size() - r0 && i < 4; i++) begin
            total++; if (rd_log[r0 + i] !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, rd_log[r0 + i], exp_a[i]); end
        end
        n = hs_val.size() - h0;
        total++; if (n !== 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            total++; if (hs_val[h0 + i] !== ref_word(int'(mem[exp_a[i]]))) begin bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, hs_val[h0 + i], ref_word(int'(mem[exp_a[i]]))); end
        end
    endtask

    task automatic test_zero_and_busy_start();
        int s, s2, h0, r0, d0, n;
        bit ok;
        rdy_mode = 0;
        r0 = rd_log.size(); d0 = done_log.size();
        pulse_start(5, 0, s);
        wait_done(20, ok);
        idle_cycles(2);
        total++; if (!ok) begin bad++; $display("FAIL zero_done_timeout: got no done want done"); end
        total++; if (done_log.size() <= d0 || done_log[d0] !== s + 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want %0d", (done_log.size() > d0) ? done_log[d0] : -1, s + 1); end
        total++; if (rd_log.size() - r0 !== 0) begin bad++; $display("FAIL zero_rd_en: got %0d pulses want 0", rd_log.size() - r0); end

        fill_random();
        rdy_mode = 1;
        h0 = hs_val.size(); r0 = rd_log.size(); d0 = done_log.size();
        pulse_start(16, 16, s);
        idle_cycles(6);
        pulse_start(0, 3, s2);
        wait_done(400, ok);
        rdy_mode = 0;
        idle_cycles(10);
        total++; if (!ok) begin bad++; $display("FAIL busy_done_timeout: got no done want done"); end
        n = hs_val.size() - h0;
        total++; if (n !== 16) begin bad++; $display("FAIL busy_count: got %0d want 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            total++; if (hs_val[h0 + i] !== ref_word(int'(mem[16 + i]))) begin bad++; $display("FAIL busy_data[%0d]: got %0d want %0d", i, hs_val[h0 + i], ref_word(int'(mem[16 + i]))); end
        end
        total++; if (rd_log.size() - r0 !== 16) begin bad++; $display("FAIL busy_rd_count: got %0d want 16", rd_log.size() - r0); end
        total++; if (done_log.size() - d0 !== 1) begin bad++; $display("FAIL busy_done_pulses: got %0d want 1", done_log.size() - d0); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL busy_idle_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_reset_mid_stream();
        int s, h0, h1, n;
        bit ok, seen;
        fill_random();
        rdy_mode = 0;
        h0 = hs_val.size();
        pulse_start(16, 16, s);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (hs_val.size() - h0 >= 5) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_5th_hs_timeout: got %0d handshakes want 5", hs_val.size() - h0); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0)      begin bad++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
        total++; if (bus.rd_en !== 1'b0)     begin bad++; $display("FAIL rstmid_rd_en: got %b want 0", bus.rd_en); end
        h1 = hs_val.size();
        pulse_start(0, 2, s);
        wait_done(50, ok);
        idle_cycles(2);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_done_timeout: got no done want done"); end
        n = hs_val.size() - h1;
        total++; if (n !== 2) begin bad++; $display("FAIL rstmid_count: got %0d want 2", n); end
        for (int i = 0; i < n && i < 2; i++) begin
            total++; if (hs_val[h1 + i] !== ref_word(int'(mem[i]))) begin bad++; $display("FAIL rstmid_data[%0d]: got %0d want %0d", i, hs_val[h1 + i], ref_word(int'(mem[i]))); end
        end
    endtask

    task automatic test_random_transfers();
        int s, b, c, h0, r0, sv0, o0, n, exp_a;
        bit ok;
        for (int it = 0; it < 6; it++) begin
            fill_random();
            b = $urandom_range(0, DEPTH - 1);
            c = $urandom_range(1, DEPTH);
            rdy_mode = 1;
            h0 = hs_val.size(); r0 = rd_log.size(); sv0 = stall_viol; o0 = over2;
            pulse_start(b, c, s);
            wait_done(600, ok);
            rdy_mode = 0;
            idle_cycles(2);
            total++; if (!ok) begin bad++; $display("FAIL rand%0d_done_timeout: got no done want done", it); end
            n = hs_val.size() - h0;
            total++; if (n !== c) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", it, n, c); end
            total++; if (rd_log.size() - r0 !== c) begin bad++; $display("FAIL rand%0d_rd_count: got %0d want %0d", it, rd_log.size() - r0, c); end
            for (int i = 0; i < n && i < c; i++) begin
                exp_a = (b + i) % DEPTH;
                total++; if (hs_val[h0 + i] !== ref_word(int'(mem[exp_a]))) begin bad++; $display("FAIL rand%0d_data[%0d]: got %0d want %0d", it, i, hs_val[h0 + i], ref_word(int'(mem[exp_a]))); end
                if (i < rd_log.size() - r0) begin
                    total++; if (rd_log[r0 + i] !== exp_a) begin bad++; $display("FAIL rand%0d_addr[%0d]: got %0d want %0d", it, i, rd_log[r0 + i], exp_a); end
                end
            end
            total++; if (stall_viol - sv0 !== 0) begin bad++; $display("FAIL rand%0d_stall_stable: got %0d want 0", it, stall_viol - sv0); end
            total++; if (over2 - o0 !== 0) begin bad++; $display("FAIL rand%0d_outstanding: got %0d want 0", it, over2 - o0); end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.count     = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_full_rate();
        test_backpressure();
        test_saturation();
        test_wrap();
        test_zero_and_busy_start();
        test_reset_mid_stream();
        test_random_transfers();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
